fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage between `ProgramCounter` and decode. Each cycle it can issue the current PC to instruction memory, keeping at most one request outstanding. Returned words are buffered in a small queue and handed to decode with a valid/ready handshake. It drives `pc_advance` to step the PC only when a fetch is accepted, and discards in-flight and buffered work on a redirect (`flush`).

## Interface
Parameters:
- `DEPTH`, 2: fetch queue entries, ≥2, power of two.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_address`  in  32  current PC from `ProgramCounter`.
- `pc_advance`  out  1  PC may step to +4 at the next edge (combinational).
- `flush`  in  1  redirect this cycle; same signal as the PC's `jump_en`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  request address, equal to `pc_address`.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid; arrives ≥1 cycle after grant, in order.
- `imem_rdata`  in  32  instruction word.
- `out_valid`  out  1  entry available to decode.
- `out_ready`  in  1  decode accepts the entry.
- `out_instr`  out  32  instruction.
- `out_pc`  out  32  PC of `out_instr`.
- `out_fault`  out  1  misaligned-fetch fault marker.

## Operation
- State is one of IDLE, WAIT, DRAIN and FAULT.
- **Reset values:**
  - State is IDLE and the queue is empty.
  - `imem_req`, `pc_advance`, `out_valid` and `out_fault` are 0.
  - `out_instr` and `out_pc` are 0.
- **IDLE:**
  - Assert `imem_req` when `!flush`, `pc_address[1:0]==0` and `count < DEPTH`.
  - On `imem_req && imem_gnt`:
    - Assert `pc_advance`.
    - Latch `pc_address` into the outstanding-PC register.
    - Go to WAIT.
- **WAIT:**
  - No request is issued.
  - On `imem_rvalid`, push `{outstanding_pc, imem_rdata, 0}` and go to IDLE.
  - Slot reservation guarantees the push never overflows. The issue condition in IDLE is `count < DEPTH`, evaluated with the outstanding slot already counted.
- **Misaligned PC in IDLE** (`pc_address[1:0]!=0`, not flush, space free):
  - No memory request is made.
  - Push `{pc_address, 32'h0000_0013, 1}`.
  - Go to FAULT.
- **FAULT:**
  - Nothing is issued and `pc_advance` stays 0.
  - Leave only on `flush`.
- **`flush` (any state):**
  - The queue is cleared at the edge.
  - `imem_req` and `pc_advance` are forced to 0 in that cycle.
  - From WAIT: go to DRAIN, unless `imem_rvalid` is present in the same cycle; then discard the data and go to IDLE.
  - From IDLE, DRAIN or FAULT: go to IDLE, except that DRAIN stays DRAIN if no response has arrived yet.
- **DRAIN:**
  - The next `imem_rvalid` is discarded, then go to IDLE.
  - No request is issued while in DRAIN.
- **Request withdrawal:** an ungranted `imem_req` may be dropped only on `flush`. Otherwise `imem_req` and `imem_addr` stay stable until grant; this holds because `pc_advance` stays 0 until then.
- **Queue behaviour:**
  - The queue is FIFO; the head drives the `out_*` signals.
  - A pop occurs on `out_valid && out_ready`.
  - Simultaneous push and pop is allowed at any fill level, including full.
  - `flush` dominates both push and pop.
- **Arithmetic:** `count` is `$clog2(DEPTH)+1` bits. Pointers wrap modulo DEPTH.

## Timing
- Grant at edge t; `imem_rvalid` at t+1 at the earliest; `out_valid` from t+2 (registered queue, no bypass).
- Back-to-back issue: a grant in cycle t allows the next request in cycle t+2 at the earliest (rvalid at t+1 returns to IDLE). Peak throughput is one instruction per 2 cycles with 1-cycle memory.
- `pc_advance` is high exactly in grant cycles, so the PC steps once per accepted fetch.
- `out_*` hold stable while `out_valid && !out_ready`.
- A flush at edge t gives `out_valid=0` from t+1, and the first new request can be granted in cycle t+1.

## Structure
- Put the following in `riscv_pkg`:
  - `fetch_state_t` enum (IDLE, WAIT, DRAIN, FAULT).
  - `fetch_entry_t` struct `{pc, instr, fault}`.
  - `NOP_INSTR = 32'h0000_0013`.
- Put the queue in sub-module `fetch_queue`: parameterised `DEPTH`, with push, pop, clear, count, full and empty.

## Test plan
- Reset, then memory granting immediately with 1-cycle rvalid; PC 0,4,8 returning 0x11,0x22,0x33 with `out_ready=1` → entries (0,0x11), (4,0x22), (8,0x33) in order. `pc_advance` pulses once per grant.
- `out_ready=0` with DEPTH=2 → exactly 2 entries buffered and `imem_req` stays low. Raising `out_ready` → both drain, then fetching resumes at PC 8.
- Grant of PC 0x10, `flush` with jump to 0x40 before rvalid, then late rvalid with 0xDEAD → 0xDEAD is never output and the first output is PC 0x40.
- `flush` in the same cycle as rvalid in WAIT → data dropped and the state is IDLE on the next edge.
- PC 0x6 → output `{0x6, 0x00000013, fault=1}` with no `imem_req`. The block stays idle until `flush` to 0x100, then fetches 0x100.
- `reset` asserted while in WAIT with a full queue → all outputs return to their reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: FSM state encoding, queue entry layout and the
// filler instruction used for fault entries.
package riscv_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDrain,
      StFault
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } fetch_entry_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: PC coupling, instruction-memory request/response and the
// decode-facing valid/ready channel.
interface fetch_unit_if;

   logic [31:0] pc_address;
   logic        pc_advance;
   logic        flush;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_fault;

   modport master (
      input  pc_address, flush, imem_gnt, imem_rvalid, imem_rdata, out_ready,
      output pc_advance, imem_req, imem_addr, out_valid, out_instr, out_pc, out_fault
   );

   modport slave (
      output pc_address, flush, imem_gnt, imem_rvalid, imem_rdata, out_ready,
      input  pc_advance, imem_req, imem_addr, out_valid, out_instr, out_pc, out_fault
   );

endinterface

// File: rtl/fetch_queue.sv
// Registered FIFO of fetched entries; clear dominates push and pop, and a
// push is accepted at full when a pop happens in the same cycle.
module fetch_queue
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     clear,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   fetch_entry_t          mem [DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]       count_q;
   logic                  do_push, do_pop;

   assign count   = count_q;
   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(DEPTH));
   assign do_pop  = pop && !empty && !clear;
   assign do_push = push && (!full || do_pop) && !clear;
   assign head    = mem[rd_ptr_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   // Storage needs no reset: outputs are qualified by the count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, responses buffered
// in a small queue toward decode, redirects discard in-flight and queued work.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   fetch_state_t     state_q, state_d;
   logic [31:0]      pend_pc_q, pend_pc_d;
   logic             aligned, space_free, issue;
   logic             fsm_push, q_push, q_pop, q_full, q_empty;
   logic [CntW-1:0]  q_count;
   fetch_entry_t     push_entry, head;

   assign aligned    = (bus.pc_address[1:0] == 2'b00);
   // The outstanding request's slot is reserved by issuing only below DEPTH.
   assign space_free = (q_count < CntW'(DEPTH));
   assign issue      = !reset && (state_q == StIdle) && !bus.flush && aligned && space_free;

   assign bus.imem_req   = issue;
   assign bus.imem_addr  = bus.pc_address;
   assign bus.pc_advance = issue && bus.imem_gnt;

   always_comb begin
      state_d    = state_q;
      pend_pc_d  = pend_pc_q;
      fsm_push   = 1'b0;
      push_entry = '{pc: bus.pc_address, instr: NOP_INSTR, fault: 1'b1};
      unique case (state_q)
         StIdle: begin
            if (!bus.flush && space_free) begin
               if (aligned) begin
                  if (bus.imem_gnt) begin
                     pend_pc_d = bus.pc_address;
                     state_d   = StWait;
                  end
               end else begin
                  fsm_push = 1'b1;
                  state_d  = StFault;
               end
            end
         end
         StWait: begin
            if (bus.flush) begin
               state_d = bus.imem_rvalid ? StIdle : StDrain;
            end else if (bus.imem_rvalid) begin
               fsm_push   = 1'b1;
               push_entry = '{pc: pend_pc_q, instr: bus.imem_rdata, fault: 1'b0};
               state_d    = StIdle;
            end
         end
         StDrain: begin
            if (bus.imem_rvalid) state_d = StIdle;
         end
         StFault: begin
            if (bus.flush) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   assign q_pop  = bus.out_valid && bus.out_ready;
   assign q_push = fsm_push && (!q_full || q_pop);

   fetch_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .clk      (clk),
      .reset    (reset),
      .push     (q_push),
      .push_data(push_entry),
      .pop      (q_pop),
      .clear    (bus.flush),
      .head     (head),
      .count    (q_count),
      .full     (q_full),
      .empty    (q_empty)
   );

   assign bus.out_valid = !q_empty;
   assign bus.out_pc    = q_empty ? 32'h0 : head.pc;
   assign bus.out_instr = q_empty ? 32'h0 : head.instr;
   assign bus.out_fault = !q_empty && head.fault;

endmodule
